// File: rtl/expr_eval.sv
// expr_eval: evaluates a D((+|*)D)* character stream with '*' binding tighter than '+'
module expr_eval #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    input  logic             in_valid,
    output logic             out,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             ovf
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] NUM  = 3'd1;
    localparam logic [2:0] OPA  = 3'd2;
    localparam logic [2:0] OPM  = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;
    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d, t_q, t_d, result_q;
    logic             ovf_q, ovf_d, t_wrap;
    logic             is_dig;
    logic [3:0]       dig;
    logic [WIDTH+3:0] prod;
    logic [WIDTH:0]   tot;
    assign is_dig = (in >= 8'd48) && (in <= 8'd57);
    assign dig    = in[3:0];
    assign prod   = {4'b0, t_q} * {{WIDTH{1'b0}}, dig};
    assign tot    = {1'b0, s_d} + {1'b0, t_d};
    assign ovf_d  = ovf_q | (in_valid && state_d != ERR && (t_wrap || tot[WIDTH]));
    // grammar FSM and sum/term update for one accepted character; ERR freezes everything
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        t_d     = t_q;
        t_wrap  = 1'b0;
        if (in_valid) begin
            case (state_q)
                IDLE, OPA: begin
                    state_d = is_dig ? NUM : ERR;
                    t_d     = is_dig ? WIDTH'(dig) : t_q;
                end
                NUM: begin
                    state_d = (in == 8'd43) ? OPA : (in == 8'd42) ? OPM : ERR;
                    s_d     = (in == 8'd43) ? s_q + t_q : s_q;
                    t_d     = (in == 8'd43) ? '0 : t_q;
                end
                OPM: begin
                    state_d = is_dig ? NUM : ERR;
                    t_d     = is_dig ? prod[WIDTH-1:0] : t_q;
                    t_wrap  = is_dig && (|prod[WIDTH+3:WIDTH]);
                end
                default: state_d = ERR;
            endcase
        end
    end
    // state and arithmetic registers; result tracks S+T of the accepted prefix
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            s_q      <= '0;
            t_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            t_q      <= t_d;
            result_q <= tot[WIDTH-1:0];
            ovf_q    <= ovf_d;
        end
    end
    assign out    = (state_q == NUM);
    assign err    = (state_q == ERR);
    assign result = result_q;
    assign ovf    = ovf_q;
endmodule
